// File: rtl/fir_tdm_ctrl_pkg.sv
// rtl/fir_tdm_ctrl_pkg.sv - shared state encoding and constants for the TDM FIR controller
package fir_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MAC  = 2'd1;
  localparam logic [1:0] S_OUT  = 2'd2;

  function automatic int tap_w(input int ntaps);
    return (ntaps > 1) ? $clog2(ntaps) : 1;
  endfunction

  function automatic int default_coef(input int idx);
    case (idx)
      0:       return -2;
      1:       return -1;
      2:       return 3;
      3:       return 4;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/fir_tdm_ctrl_if.sv
// rtl/fir_tdm_ctrl_if.sv - sample, result and coefficient-config signals of the FIR controller
interface fir_tdm_ctrl_if
  import fir_pkg::*;
#(
  parameter int NTAPS = 4,
  parameter int DW    = 8,
  parameter int CW    = 8,
  parameter int OW    = 16,
  parameter int AW    = tap_w(NTAPS)
);

  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] xin;
  logic                 approx_en;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [OW-1:0] yout;
  logic                 cfg_we;
  logic [AW-1:0]        cfg_addr;
  logic signed [CW-1:0] cfg_data;
  logic                 cfg_ready;

  modport master (
    output in_valid, xin, approx_en, out_ready, cfg_we, cfg_addr, cfg_data,
    input  in_ready, out_valid, yout, cfg_ready
  );

  modport slave (
    input  in_valid, xin, approx_en, out_ready, cfg_we, cfg_addr, cfg_data,
    output in_ready, out_valid, yout, cfg_ready
  );

endinterface

// File: rtl/fir_tdm_ctrl_approx_add.sv
// rtl/fir_tdm_ctrl_approx_add.sv - adder with optional low-bit approximation (no carry out of the low K bits)
module approx_add #(
  parameter int OW = 16,
  parameter int K  = 3
) (
  input  logic [OW-1:0] a,
  input  logic [OW-1:0] b,
  input  logic          en,
  output logic [OW-1:0] sum
);

  logic [OW-1:0] w_exact;
  assign w_exact = a + b;

  generate
    if (K > 0 && K < OW) begin : g_approx
      logic [OW-K-1:0] w_upper;
      logic [K-1:0]    w_lower;
      assign w_upper = a[OW-1:K] + b[OW-1:K];
      // Saturate the low field when bit K disagrees, instead of propagating a carry.
      assign w_lower = (a[K] ^ b[K]) ? {K{1'b1}} : (a[K-1:0] + b[K-1:0]);
      assign sum     = en ? {w_upper, w_lower} : w_exact;
    end else begin : g_exact
      logic w_unused_en;
      assign w_unused_en = en;
      assign sum         = w_exact;
    end
  endgenerate

endmodule

// File: rtl/fir_tdm_ctrl.sv
// rtl/fir_tdm_ctrl.sv - time-multiplexed FIR sequencer: delay line, runtime coefficients, one shared MAC
module fir_tdm_ctrl
  import fir_pkg::*;
#(
  parameter int NTAPS       = 4,
  parameter int DW          = 8,
  parameter int CW          = 8,
  parameter int OW          = 16,
  parameter int APPROX_BITS = 3
) (
  input logic           i_clk,
  input logic           i_rst_n,
  fir_tdm_ctrl_if.slave bus
);

  localparam int            AW       = tap_w(NTAPS);
  localparam int            PW       = DW + CW;
  localparam logic [AW-1:0] LAST_TAP = AW'(NTAPS - 1);

  logic [1:0]           r_state;
  logic signed [DW-1:0] r_x [NTAPS];
  logic signed [CW-1:0] r_h [NTAPS];
  logic signed [OW-1:0] r_acc;
  logic signed [OW-1:0] r_yout;
  logic [AW-1:0]        r_k;
  logic                 r_approx;
  logic                 r_out_valid;

  logic                 w_idle;
  logic                 w_accept;
  logic signed [PW-1:0] w_prod_full;
  logic signed [OW-1:0] w_prod;
  logic [OW-1:0]        w_sum;

  assign w_idle        = (r_state == S_IDLE);
  assign bus.in_ready  = i_rst_n & w_idle & ~bus.cfg_we;
  assign bus.cfg_ready = i_rst_n & w_idle;
  assign w_accept      = bus.in_valid & bus.in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.yout      = r_yout;

  assign w_prod_full = PW'(r_h[r_k]) * PW'(r_x[r_k]);
  assign w_prod      = OW'(w_prod_full);

  approx_add #(
    .OW (OW),
    .K  (APPROX_BITS)
  ) u_approx_add (
    .a   (r_acc),
    .b   (w_prod),
    .en  (r_approx),
    .sum (w_sum)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_yout      <= '0;
      r_k         <= '0;
      r_approx    <= 1'b0;
      r_out_valid <= 1'b0;
      for (int i = 0; i < NTAPS; i++) begin
        r_x[i] <= '0;
        r_h[i] <= CW'(default_coef(i));
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.cfg_we) begin
            r_h[bus.cfg_addr] <= bus.cfg_data;
          end else if (w_accept) begin
            r_x[0] <= bus.xin;
            for (int i = 1; i < NTAPS; i++) r_x[i] <= r_x[i-1];
            r_approx <= bus.approx_en;
            r_acc    <= '0;
            r_k      <= '0;
            r_state  <= S_MAC;
          end
        end
        S_MAC: begin
          // Only the last tap goes through the (possibly approximate) adder.
          if (r_k == LAST_TAP) begin
            r_yout      <= w_sum;
            r_out_valid <= 1'b1;
            r_state     <= S_OUT;
          end else begin
            r_acc <= r_acc + w_prod;
            r_k   <= r_k + AW'(1);
          end
        end
        S_OUT: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
